// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the 8080-style LCD bus masters: FSM states, default
// bus timing and the panel command codes used for readback.
package lcd_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD_SETUP = 3'd1,
        ST_CMD_WRL   = 3'd2,
        ST_CMD_WRH   = 3'd3,
        ST_TURN      = 3'd4,
        ST_RD_LO     = 3'd5,
        ST_RD_HI     = 3'd6,
        ST_FINISH    = 3'd7
    } lcd_state_e;

    localparam int DEF_T_WRL  = 2;
    localparam int DEF_T_WRH  = 2;
    localparam int DEF_T_TURN = 4;
    localparam int DEF_T_RDL  = 8;
    localparam int DEF_T_RDH  = 4;

    // Phase timer width; every timing parameter must fit in TMR_W bits.
    localparam int TMR_W = 8;

    localparam logic [15:0] CMD_RDID4 = 16'h00D3;
    localparam logic [15:0] CMD_RDST  = 16'h0009;
    localparam logic [15:0] CMD_RAMRD = 16'h002E;

    // A state lasting n cycles loads the down-counter with n-1.
    function automatic logic [TMR_W-1:0] tmr_load(input int cycles);
        return TMR_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times each bus phase; zero marks the last cycle
// of the current phase.
module lcd_phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_r;

    // Count down to zero and park there until the next load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {WIDTH{1'b0}}) begin
            cnt_r <= cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {WIDTH{1'b0}});

endmodule

// File: rtl/lcd_reg_reader.sv
// Read-side master for the parallel LCD bus: one command write, bus turnaround,
// then a burst of read strobes whose captured words are reported one by one.
module lcd_reg_reader
    import lcd_bus_pkg::*;
#(
    parameter int T_WRL         = DEF_T_WRL,
    parameter int T_WRH         = DEF_T_WRH,
    parameter int T_TURN        = DEF_T_TURN,
    parameter int T_RDL         = DEF_T_RDL,
    parameter int T_RDH         = DEF_T_RDH,
    parameter int DISCARD_FIRST = 1,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [15:0]          cmd,
    input  logic [CNT_WIDTH-1:0] rd_count,
    output logic                 busy,
    output logic [15:0]          rd_data,
    output logic                 rd_valid,
    output logic                 done,
    output logic                 LCD_CS,
    output logic                 LCD_RS,
    output logic                 LCD_WR,
    output logic                 LCD_RD,
    output logic [15:0]          LCD_DATA_O,
    output logic                 LCD_DATA_OE,
    input  logic [15:0]          LCD_DATA_I
);

    localparam int RW = CNT_WIDTH + 1;

    lcd_state_e       state_r;
    lcd_state_e       next_state_s;
    logic             tmr_load_s;
    logic [TMR_W-1:0] tmr_val_s;
    logic             tmr_zero_s;

    logic [15:0]      cmd_r;
    logic [RW-1:0]    total_r;
    logic [RW-1:0]    rd_cnt_r;
    logic [15:0]      cap_r;
    logic             cap_pend_r;
    logic             rd_last_s;
    logic [15:0]      cmd_src_s;

    logic             cs_s, rs_s, wr_s, rd_s, oe_s, busy_s, done_s;
    logic [15:0]      dout_s;
    logic             cs_r, rs_r, wr_r, rd_r, oe_r, busy_r, done_r, rd_valid_r;
    logic [15:0]      dout_r, rd_data_r;

    lcd_phase_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    assign rd_last_s = (state_r == ST_RD_LO) && tmr_zero_s;
    // The command is not latched yet on the IDLE->CMD_SETUP edge.
    assign cmd_src_s = (state_r == ST_IDLE) ? cmd : cmd_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; each transition reloads the phase timer for the new state.
    always_comb begin
        next_state_s = state_r;
        tmr_load_s   = 1'b0;
        tmr_val_s    = {TMR_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_CMD_SETUP;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = tmr_load(1);
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CMD_SETUP: begin
                if (tmr_zero_s) begin
                    next_state_s = ST_CMD_WRL;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = tmr_load(T_WRL);
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_CMD_WRL: begin
                if (tmr_zero_s) begin
                    next_state_s = ST_CMD_WRH;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = tmr_load(T_WRH);
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_CMD_WRH: begin
                if (tmr_zero_s) begin
                    tmr_load_s = 1'b1;
                    if (total_r == {RW{1'b0}}) begin
                        next_state_s = ST_FINISH;
                        tmr_val_s    = tmr_load(1);
                    end else begin
                        next_state_s = ST_TURN;
                        tmr_val_s    = tmr_load(T_TURN);
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_TURN: begin
                if (tmr_zero_s) begin
                    next_state_s = ST_RD_LO;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = tmr_load(T_RDL);
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_RD_LO: begin
                if (tmr_zero_s) begin
                    next_state_s = ST_RD_HI;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = tmr_load(T_RDH);
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_RD_HI: begin
                if (tmr_zero_s) begin
                    tmr_load_s = 1'b1;
                    if (rd_cnt_r >= total_r) begin
                        next_state_s = ST_FINISH;
                        tmr_val_s    = tmr_load(1);
                    end else begin
                        next_state_s = ST_RD_LO;
                        tmr_val_s    = tmr_load(T_RDL);
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_FINISH: begin
                if (tmr_zero_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Request latch and read counter; the counter is one bit wider than rd_count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_r    <= 16'h0000;
            total_r  <= {RW{1'b0}};
            rd_cnt_r <= {RW{1'b0}};
        end else if ((state_r == ST_IDLE) && start) begin
            cmd_r    <= cmd;
            total_r  <= {1'b0, rd_count} + RW'(DISCARD_FIRST);
            rd_cnt_r <= {RW{1'b0}};
        end else if (rd_last_s) begin
            cmd_r    <= cmd_r;
            total_r  <= total_r;
            rd_cnt_r <= rd_cnt_r + {{(RW-1){1'b0}}, 1'b1};
        end else begin
            cmd_r    <= cmd_r;
            total_r  <= total_r;
            rd_cnt_r <= rd_cnt_r;
        end
    end

    // Two-flop capture: bus sampled on the last RD low cycle, published one cycle later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cap_r      <= 16'h0000;
            cap_pend_r <= 1'b0;
            rd_data_r  <= 16'h0000;
            rd_valid_r <= 1'b0;
        end else begin
            cap_r      <= rd_last_s ? LCD_DATA_I : cap_r;
            cap_pend_r <= rd_last_s;
            rd_data_r  <= cap_pend_r ? cap_r : rd_data_r;
            rd_valid_r <= cap_pend_r &&
                          !((DISCARD_FIRST != 0) && (rd_cnt_r == RW'(1)));
        end
    end

    // Pin values decoded from the state being entered, so the registered pins track state_r.
    always_comb begin
        cs_s   = 1'b1;
        rs_s   = 1'b1;
        wr_s   = 1'b1;
        rd_s   = 1'b1;
        oe_s   = 1'b0;
        dout_s = 16'h0000;
        busy_s = 1'b1;
        done_s = 1'b0;
        case (next_state_s)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_CMD_SETUP, ST_CMD_WRH: begin
                cs_s   = 1'b0;
                rs_s   = 1'b0;
                oe_s   = 1'b1;
                dout_s = cmd_src_s;
            end
            ST_CMD_WRL: begin
                cs_s   = 1'b0;
                rs_s   = 1'b0;
                wr_s   = 1'b0;
                oe_s   = 1'b1;
                dout_s = cmd_src_s;
            end
            ST_TURN, ST_RD_HI: begin
                cs_s = 1'b0;
            end
            ST_RD_LO: begin
                cs_s = 1'b0;
                rd_s = 1'b0;
            end
            ST_FINISH: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Output registers; reset returns every pin to its idle level at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cs_r   <= 1'b1;
            rs_r   <= 1'b1;
            wr_r   <= 1'b1;
            rd_r   <= 1'b1;
            oe_r   <= 1'b0;
            dout_r <= 16'h0000;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            cs_r   <= cs_s;
            rs_r   <= rs_s;
            wr_r   <= wr_s;
            rd_r   <= rd_s;
            oe_r   <= oe_s;
            dout_r <= dout_s;
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    assign LCD_CS      = cs_r;
    assign LCD_RS      = rs_r;
    assign LCD_WR      = wr_r;
    assign LCD_RD      = rd_r;
    assign LCD_DATA_OE = oe_r;
    assign LCD_DATA_O  = dout_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign rd_data     = rd_data_r;
    assign rd_valid    = rd_valid_r;

endmodule

// File: tb/tb_lcd_reg_reader.sv
// Scoreboard bench for lcd_reg_reader: a panel model answers read strobes,
// expected words are queued at issue time and a monitor pops them on rd_valid.
module tb_lcd_reg_reader;
    import lcd_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start, start0;
    logic [15:0] cmd, cmd0;
    logic [7:0]  rd_count, rd_count0;
    logic [15:0] data_i;

    logic        busy, rd_valid, done, cs, rs, wr, rd, oe;
    logic [15:0] rd_data, dout;
    logic        busy0, rd_valid0, done0, cs0, rs0, wr0, rd0, oe0;
    logic [15:0] rd_data0, dout0;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    logic [15:0] panel [0:299];
    int pidx = 0;

    int done_cnt, valid_cnt, rd_falls, rd_lo_cyc, wr_lo_cyc;
    int done0_cnt, valid0_cnt, rd0_falls, wr0_lo_cyc;
    int viol = 0;
    logic rd_prev = 1'b1;
    logic rd0_prev = 1'b1;

    always #5 clk = ~clk;

    lcd_reg_reader u_dut (
        .clk(clk), .rstn(rstn), .start(start), .cmd(cmd), .rd_count(rd_count),
        .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
        .LCD_CS(cs), .LCD_RS(rs), .LCD_WR(wr), .LCD_RD(rd),
        .LCD_DATA_O(dout), .LCD_DATA_OE(oe), .LCD_DATA_I(data_i)
    );

    lcd_reg_reader #(.DISCARD_FIRST(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .start(start0), .cmd(cmd0), .rd_count(rd_count0),
        .busy(busy0), .rd_data(rd_data0), .rd_valid(rd_valid0), .done(done0),
        .LCD_CS(cs0), .LCD_RS(rs0), .LCD_WR(wr0), .LCD_RD(rd0),
        .LCD_DATA_O(dout0), .LCD_DATA_OE(oe0), .LCD_DATA_I(data_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Panel: stale value right after RD falls, real word settles mid-strobe.
    initial begin
        data_i = 16'h0000;
        forever begin
            @(negedge rd);
            data_i = 16'hFFFF;
            repeat (5) @(posedge clk);
            #1;
            data_i = (pidx < 300) ? panel[pidx] : 16'hBAD0;
            pidx++;
        end
    end

    // Monitor: scoreboard pops, strobe statistics, bus-safety watch.
    always @(negedge clk) begin
        if (rd_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rd_valid actual=0x%0h expected=none", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd_data", {16'h0000, rd_data}, {16'h0000, mon_exp});
            end
        end
        if (done) done_cnt++;
        if (!wr) wr_lo_cyc++;
        if (!rd) rd_lo_cyc++;
        if (rd_prev && !rd) rd_falls++;
        rd_prev = rd;
        if (oe && !rd) viol++;
        if (busy && !done && cs) viol++;
        if (rd_valid0) valid0_cnt++;
        if (done0) done0_cnt++;
        if (!wr0) wr0_lo_cyc++;
        if (rd0_prev && !rd0) rd0_falls++;
        rd0_prev = rd0;
        if (oe0 && !rd0) viol++;
        if (busy0 && !done0 && cs0) viol++;
    end

    task automatic clear_stats();
        done_cnt = 0; valid_cnt = 0; rd_falls = 0; rd_lo_cyc = 0; wr_lo_cyc = 0;
        done0_cnt = 0; valid0_cnt = 0; rd0_falls = 0; wr0_lo_cyc = 0;
    endtask

    // Returns at the negedge inside CMD_SETUP (cycle 1 of the transaction).
    task automatic issue(input bit main, input logic [15:0] c, input logic [7:0] n);
        @(negedge clk);
        if (main) begin
            start = 1'b1; cmd = c; rd_count = n;
        end else begin
            start0 = 1'b1; cmd0 = c; rd_count0 = n;
        end
        @(negedge clk);
        start = 1'b0;
        start0 = 1'b0;
    endtask

    task automatic wait_done(input bit main, input int budget, output int cyc, output bit ok);
        cyc = 1;
        ok = 1'b0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (main ? done : done0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=%0d expected<%0d", cyc, budget);
        end
    endtask

    int  cyc;
    bit  ok;
    int  w;

    initial begin
        rstn = 1'b0; start = 1'b0; start0 = 1'b0;
        cmd = 16'h0000; cmd0 = 16'h0000; rd_count = 8'd0; rd_count0 = 8'd0;
        clear_stats();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_pins", {27'd0, cs, rs, wr, rd, oe}, 32'h1E);
        check("idle_data_o", {16'h0000, dout}, 32'h0);
        check("idle_flags", {29'd0, busy, done, rd_valid}, 32'h0);
        check("idle_rd_data", {16'h0000, rd_data}, 32'h0);

        // Panel ID read
        clear_stats(); pidx = 0;
        panel[0] = 16'hDEAD; panel[1] = 16'h0000; panel[2] = 16'h0093; panel[3] = 16'h0041;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0093); exp_q.push_back(16'h0041);
        issue(1'b1, CMD_RDID4, 8'd3);
        check("id_setup_pins", {28'd0, cs, rs, oe, busy}, 32'h3);
        check("id_setup_data", {16'h0000, dout}, 32'h00D3);
        wait_done(1'b1, 200, cyc, ok);
        if (ok) begin
            check("id_done_cycle", cyc, 32'd58);
            check("id_busy_at_done", {31'd0, busy}, 32'd1);
            @(negedge clk);
            check("id_busy_after_done", {31'd0, busy}, 32'd0);
        end
        repeat (2) @(negedge clk);
        check("id_queue_empty", exp_q.size(), 32'd0);
        check("id_valid_cnt", valid_cnt, 32'd3);
        check("id_done_cnt", done_cnt, 32'd1);
        check("id_wr_low", wr_lo_cyc, 32'd2);
        check("id_rd_strobes", rd_falls, 32'd4);
        check("id_rd_low", rd_lo_cyc, 32'd32);

        // Command only, no dummy read
        clear_stats();
        issue(1'b0, CMD_RDST, 8'd0);
        wait_done(1'b0, 50, cyc, ok);
        if (ok) check("cmdonly_done_cycle", cyc, 32'd6);
        repeat (2) @(negedge clk);
        check("cmdonly_rd_strobes", rd0_falls, 32'd0);
        check("cmdonly_valid", valid0_cnt, 32'd0);
        check("cmdonly_wr_low", wr0_lo_cyc, 32'd2);
        check("cmdonly_done_cnt", done0_cnt, 32'd1);

        // rd_count=0 with dummy: one strobe, nothing reported
        clear_stats(); pidx = 0; panel[0] = 16'h7777;
        issue(1'b1, CMD_RDST, 8'd0);
        wait_done(1'b1, 100, cyc, ok);
        if (ok) check("zero_done_cycle", cyc, 32'd22);
        repeat (2) @(negedge clk);
        check("zero_rd_strobes", rd_falls, 32'd1);
        check("zero_valid", valid_cnt, 32'd0);
        check("zero_rd_data", {16'h0000, rd_data}, 32'h7777);

        // Start while busy is ignored
        clear_stats(); pidx = 0;
        panel[0] = 16'h1111; panel[1] = 16'hA5A5; panel[2] = 16'h5A5A;
        exp_q.push_back(16'hA5A5); exp_q.push_back(16'h5A5A);
        issue(1'b1, CMD_RAMRD, 8'd2);
        w = 0;
        while (rd && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("busy_rd_low_seen", {31'd0, rd}, 32'd0);
        start = 1'b1; cmd = CMD_RDST; rd_count = 8'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b1, 200, cyc, ok);
        repeat (4) @(negedge clk);
        check("busy_done_cnt", done_cnt, 32'd1);
        check("busy_valid_cnt", valid_cnt, 32'd2);
        check("busy_queue_empty", exp_q.size(), 32'd0);
        check("busy_rd_strobes", rd_falls, 32'd3);
        check("busy_idle_after", {31'd0, busy}, 32'd0);

        // Reset during the 2nd RD low phase
        clear_stats(); pidx = 0;
        for (int i = 0; i < 5; i++) panel[i] = 16'hC000 + 16'(i);
        for (int i = 1; i < 5; i++) exp_q.push_back(16'hC000 + 16'(i));
        issue(1'b1, CMD_RAMRD, 8'd4);
        w = 0;
        while (rd_falls < 2 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("rst_second_strobe_seen", rd_falls, 32'd2);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_pins", {28'd0, cs, rd, busy, done}, 32'hC);
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_no_done", done_cnt, 32'd0);
        check("rst_no_valid", valid_cnt, 32'd0);

        clear_stats(); pidx = 0;
        panel[0] = 16'hBEEF; panel[1] = 16'h1234;
        exp_q.push_back(16'h1234);
        issue(1'b1, CMD_RAMRD, 8'd1);
        wait_done(1'b1, 100, cyc, ok);
        if (ok) check("post_rst_done_cycle", cyc, 32'd34);
        repeat (2) @(negedge clk);
        check("post_rst_valid", valid_cnt, 32'd1);
        check("post_rst_queue_empty", exp_q.size(), 32'd0);

        // Maximum count: 256 reads, counter must not wrap
        clear_stats(); pidx = 0;
        for (int i = 0; i < 300; i++) panel[i] = 16'h4000 + 16'(i);
        for (int i = 1; i < 256; i++) exp_q.push_back(16'h4000 + 16'(i));
        issue(1'b1, CMD_RAMRD, 8'd255);
        wait_done(1'b1, 4000, cyc, ok);
        if (ok) check("max_done_cycle", cyc, 32'd3082);
        repeat (2) @(negedge clk);
        check("max_valid_cnt", valid_cnt, 32'd255);
        check("max_queue_empty", exp_q.size(), 32'd0);
        check("max_rd_strobes", rd_falls, 32'd256);

        check("bus_safety_violations", viol, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_reg_reader.md
Name: lcd_reg_reader

Overview:
- Read-side master for the 8080-style parallel LCD bus (CS/RS/WR/RD/16-bit DATA) that the init and pixel writers drive.
- Per request: issues one command write (RS=0), turns the bus around, then performs N read strobes (RS=1) and returns the captured words. Typical uses are panel ID (0xD3), status (0x09) and GRAM readback (0x2E).
- Sits beside the init/write path. The top-level bus mux selects this block's pins whenever busy=1.

Parameters:
- T_WRL, 2, WR low width in clk cycles (min 1)
- T_WRH, 2, WR high width after command write (min 1)
- T_TURN, 4, cycles with DATA released before first RD falls (min 1)
- T_RDL, 8, RD low width; data sampled on last low cycle (min 1)
- T_RDH, 4, RD high width between reads (min 1)
- DISCARD_FIRST, 1, 1 = first read word is a dummy and is not reported
- CNT_WIDTH, 8, width of rd_count

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- cmd  in  16  command word written with RS=0
- rd_count  in  CNT_WIDTH  reported words wanted (dummy excluded)
- busy  out  1  high from the cycle after accepted start through FINISH
- rd_data  out  16  last captured word
- rd_valid  out  1  one-cycle pulse per reported word
- done  out  1  one-cycle pulse at end of transaction
- LCD_CS  out  1  chip select, active low
- LCD_RS  out  1  0 = command, 1 = data
- LCD_WR  out  1  write strobe, active low
- LCD_RD  out  1  read strobe, active low
- LCD_DATA_O  out  16  bus drive value
- LCD_DATA_OE  out  1  1 = drive bus (the top level instantiates the tristate)
- LCD_DATA_I  in  16  bus sample value (asynchronous to clk)

Behaviour:
- Reset, and IDLE: CS=1, RS=1, WR=1, RD=1, OE=0, DATA_O=0, busy=0, rd_valid=0, done=0, rd_data=0.
- Asserting rstn low mid-transaction forces all outputs to the IDLE values immediately. No partial done is produced.
- start in IDLE latches cmd and rd_count and goes to CMD_SETUP. start in any other state is ignored.
- Total reads R = rd_count + DISCARD_FIRST. Every state below is held for its parameter count, timed by a down-counter.
- CMD_SETUP, 1 cycle: CS=0, RS=0, OE=1, DATA_O=cmd.
- CMD_WRL, T_WRL cycles: WR=0.
- CMD_WRH, T_WRH cycles: WR=1. Data is still driven during this state (hold time).
- After CMD_WRH: if R=0, go to FINISH; otherwise go to TURN.
- TURN, T_TURN cycles: OE=0 and RS=1. OE is deasserted on the first TURN cycle, so OE is never 1 while RD=0.
- RD_LO, T_RDL cycles: RD=0. On the last cycle LCD_DATA_I goes through a 2-flop capture register.
- RD_HI, T_RDH cycles: RD=1. On the first RD_HI cycle the captured word is written to rd_data.
  - rd_valid pulses with that write, unless this is read #1 and DISCARD_FIRST=1.
- Read counter: counts up to R. If reads remain, go back to RD_LO; otherwise go to FINISH.
- FINISH, 1 cycle: CS=1 and done=1. busy drops in the next cycle, when the FSM returns to IDLE.
- busy timing: goes to 1 in CMD_SETUP and stays 1 through FINISH.
- Case rd_count=0 with DISCARD_FIRST=1: the single dummy read is still performed, but no rd_valid is produced.
- Case rd_count at maximum (255) with DISCARD_FIRST=1: R=256. The read counter is CNT_WIDTH+1 bits wide, so it does not wrap.
- FSM states: IDLE, CMD_SETUP, CMD_WRL, CMD_WRH, TURN, RD_LO, RD_HI, FINISH.
- Write cycle time is T_WRL+T_WRH clocks. Read cycle time is T_RDL+T_RDH clocks.

Decomposition:
- Package lcd_bus_pkg holds:
  - the state enum;
  - default timing constants;
  - command codes CMD_RDID4=16'h00D3, CMD_RDST=16'h0009, CMD_RAMRD=16'h002E.
- Sub-module lcd_phase_timer: loadable down-counter with load value and a `zero` flag. It is shared by all timed states and reusable by the writer.

Test Plan:
- Reset and idle: hold rstn=0 for 3 cycles, then release with no start → all pins at IDLE values, busy=0.
- ID read: defaults, cmd=16'h00D3, rd_count=3, panel model returns 0xXXXX,0x0000,0x0093,0x0041.
  - Expect exactly 3 rd_valid pulses with 0x0000, 0x0093, 0x0041.
  - Expect WR low for 2 clocks, 4 RD strobes each 8 low / 4 high.
  - Expect done once and busy to fall 1 cycle after done.
- Command only: DISCARD_FIRST=0, rd_count=0 → one WR pulse, no RD pulse, done after 6 cycles (1+2+2+1), no rd_valid.
- Turnaround safety: every scenario is checked by an assertion that OE=1 and RD=0 never occur together, and that CS=0 holds for the whole transaction.
- Start while busy: pulse start with cmd=16'h0009 during RD_LO of a RAMRD with rd_count=2 → ignored; the RAMRD completes with 2 words and done fires once.
- Reset mid-read: drop rstn during the 2nd RD_LO of an rd_count=4 read → next edge shows CS=1, RD=1, busy=0, no done.
  - After release, a new start with rd_count=1 runs normally.
